// File: rtl/canny_pkg.sv
// Shared types and helpers for the canny frame controller: FSM state encoding,
// default pixel width and the interior-window predicate.
package canny_pkg;

  localparam int PIX_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // A pixel completes a full 3x3 neighbourhood once two rows and two columns precede it.
  function automatic logic win_valid(input int unsigned x, input int unsigned y);
    return (x >= 32'd2) && (y >= 32'd2);
  endfunction

endpackage

// File: rtl/canny_line_buf.sv
// One raster line of pixel storage. A write at addr_i returns the word it
// replaces on rd_data_o in the same cycle, so two instances chain into a
// two-line delay.
module canny_line_buf
  import canny_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int DEPTH = 256,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [PIX_W-1:0] wr_data_i,
  output logic [PIX_W-1:0] rd_data_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  assign rd_data_o = mem_q[addr_i];

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/canny_frame_ctrl.sv
// Frame sequencer for the canny gradient core: builds 3x3 windows from a raster
// stream, tracks results in flight and tags each with its centre coordinate.
// Optional macro CANNY_THRESH_EN adds a per-frame binary threshold on results.
module canny_frame_ctrl
  import canny_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEF,
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int CNT_W   = 16,
  parameter int OUT_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             start,
  output logic [PIX_W-1:0] im11,
  output logic [PIX_W-1:0] im12,
  output logic [PIX_W-1:0] im13,
  output logic [PIX_W-1:0] im21,
  output logic [PIX_W-1:0] im22,
  output logic [PIX_W-1:0] im23,
  output logic [PIX_W-1:0] im31,
  output logic [PIX_W-1:0] im32,
  output logic [PIX_W-1:0] im33,
  input  logic             data_occur,
  input  logic [PIX_W-1:0] dxy,
`ifdef CANNY_THRESH_EN
  input  logic [PIX_W-1:0] thresh,
`endif
  output logic             edge_valid,
  output logic [PIX_W-1:0] edge_data,
  output logic [CNT_W-1:0] edge_x,
  output logic [CNT_W-1:0] edge_y,
  output logic             busy,
  output logic             frame_done,
  output logic             err
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int OW = $clog2(OUT_MAX + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [OW-1:0]    out_q, out_d;

  logic             pix_ready_q, start_q, busy_q, frame_done_q, err_q;
  logic             edge_valid_q;
  logic [PIX_W-1:0] edge_data_q;
  logic [CNT_W-1:0] edge_x_q, edge_y_q;
  logic [PIX_W-1:0] im11_q, im12_q, im13_q, im21_q, im22_q, im23_q;
  logic [PIX_W-1:0] im31_q, im32_q, im33_q;

  logic             accept_s, win_s, res_ok_s, last_px_s;
  logic [PIX_W-1:0] l0_rd_s, l1_rd_s, result_s;

  assign accept_s  = pix_valid && pix_ready_q && (state_q == ST_RUN);
  assign win_s     = accept_s && win_valid(32'(x_q), 32'(y_q));
  assign res_ok_s  = data_occur && (out_q != {OW{1'b0}});
  assign last_px_s = accept_s && (x_q == CNT_W'(IMG_W - 1)) && (y_q == CNT_W'(IMG_H - 1));

`ifdef CANNY_THRESH_EN
  logic [PIX_W-1:0] thresh_q;

  // Threshold is captured when a frame is launched and held for its duration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thresh_q <= {PIX_W{1'b0}};
    end else if ((state_q == ST_IDLE) && frame_start) begin
      thresh_q <= thresh;
    end
  end

  assign result_s = (dxy >= thresh_q) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
`else
  assign result_s = dxy;
`endif

  canny_line_buf #(.PIX_W(PIX_W), .DEPTH(IMG_W), .AW(AW)) u_line0 (
    .clk       (clk),
    .wr_en_i   (accept_s),
    .addr_i    (x_q[AW-1:0]),
    .wr_data_i (pix_in),
    .rd_data_o (l0_rd_s)
  );

  canny_line_buf #(.PIX_W(PIX_W), .DEPTH(IMG_W), .AW(AW)) u_line1 (
    .clk       (clk),
    .wr_en_i   (accept_s),
    .addr_i    (x_q[AW-1:0]),
    .wr_data_i (l0_rd_s),
    .rd_data_o (l1_rd_s)
  );

  // Next-state for the FSM, raster counters, result counters and in-flight count.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    out_d   = out_q;
    if (win_s && !res_ok_s) begin
      out_d = out_q + OW'(1);
    end else if (!win_s && res_ok_s) begin
      out_d = out_q - OW'(1);
    end else begin
      out_d = out_q;
    end
    if (res_ok_s) begin
      if (ox_q == CNT_W'(IMG_W - 3)) begin
        ox_d = {CNT_W{1'b0}};
        oy_d = (oy_q == CNT_W'(IMG_H - 3)) ? {CNT_W{1'b0}} : oy_q + CNT_W'(1);
      end else begin
        ox_d = ox_q + CNT_W'(1);
        oy_d = oy_q;
      end
    end else begin
      ox_d = ox_q;
      oy_d = oy_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_RUN;
          x_d     = {CNT_W{1'b0}};
          y_d     = {CNT_W{1'b0}};
          out_d   = {OW{1'b0}};
          ox_d    = {CNT_W{1'b0}};
          oy_d    = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          if (x_q == CNT_W'(IMG_W - 1)) begin
            x_d = {CNT_W{1'b0}};
            y_d = last_px_s ? {CNT_W{1'b0}} : y_q + CNT_W'(1);
          end else begin
            x_d = x_q + CNT_W'(1);
            y_d = y_q;
          end
          state_d = last_px_s ? ST_DRAIN : ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (out_q == {OW{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, counters and all registered control/result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      x_q          <= {CNT_W{1'b0}};
      y_q          <= {CNT_W{1'b0}};
      ox_q         <= {CNT_W{1'b0}};
      oy_q         <= {CNT_W{1'b0}};
      out_q        <= {OW{1'b0}};
      pix_ready_q  <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      edge_valid_q <= 1'b0;
      edge_data_q  <= {PIX_W{1'b0}};
      edge_x_q     <= {CNT_W{1'b0}};
      edge_y_q     <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      out_q        <= out_d;
      // Ready looks ahead at the updated count so the in-flight limit is never exceeded.
      pix_ready_q  <= (state_d == ST_RUN) && (out_d != OW'(OUT_MAX));
      start_q      <= win_s;
      busy_q       <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      frame_done_q <= (state_d == ST_DONE);
      err_q        <= err_q | (data_occur && (out_q == {OW{1'b0}}));
      edge_valid_q <= res_ok_s;
      if (res_ok_s) begin
        edge_data_q <= result_s;
        edge_x_q    <= ox_q + CNT_W'(1);
        edge_y_q    <= oy_q + CNT_W'(1);
      end
    end
  end

  // Window columns shift left on every accepted pixel; rows come from line1, line0, input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im11_q <= {PIX_W{1'b0}};
      im12_q <= {PIX_W{1'b0}};
      im13_q <= {PIX_W{1'b0}};
      im21_q <= {PIX_W{1'b0}};
      im22_q <= {PIX_W{1'b0}};
      im23_q <= {PIX_W{1'b0}};
      im31_q <= {PIX_W{1'b0}};
      im32_q <= {PIX_W{1'b0}};
      im33_q <= {PIX_W{1'b0}};
    end else if (accept_s) begin
      im11_q <= im12_q;
      im12_q <= im13_q;
      im13_q <= l1_rd_s;
      im21_q <= im22_q;
      im22_q <= im23_q;
      im23_q <= l0_rd_s;
      im31_q <= im32_q;
      im32_q <= im33_q;
      im33_q <= pix_in;
    end
  end

  assign pix_ready  = pix_ready_q;
  assign start      = start_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign edge_valid = edge_valid_q;
  assign edge_data  = edge_data_q;
  assign edge_x     = edge_x_q;
  assign edge_y     = edge_y_q;
  assign im11 = im11_q;
  assign im12 = im12_q;
  assign im13 = im13_q;
  assign im21 = im21_q;
  assign im22 = im22_q;
  assign im23 = im23_q;
  assign im31 = im31_q;
  assign im32 = im32_q;
  assign im33 = im33_q;

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// Scoreboard bench for canny_frame_ctrl on a 4x4 frame with a latency-configurable core model.
module tb_canny_frame_ctrl;

  localparam int PW = 16;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int CW = 16;
  localparam int OM = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          frame_start = 1'b0;
  logic [PW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          data_occur = 1'b0;
  logic [PW-1:0] dxy = '0;
  logic          pix_ready, start, edge_valid, busy, frame_done, err;
  logic [PW-1:0] im11, im12, im13, im21, im22, im23, im31, im32, im33, edge_data;
  logic [CW-1:0] edge_x, edge_y;
`ifdef CANNY_THRESH_EN
  logic [PW-1:0] thresh = 16'd7;
  logic [PW-1:0] exp_data_tbl [4] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
`else
  logic [PW-1:0] exp_data_tbl [4] = '{16'd5, 16'd6, 16'd9, 16'd10};
`endif
  int exp_x_tbl [4] = '{1, 2, 1, 2};
  int exp_y_tbl [4] = '{1, 1, 2, 2};

  canny_frame_ctrl #(.PIX_W(PW), .IMG_W(IW), .IMG_H(IH), .CNT_W(CW), .OUT_MAX(OM)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pix_in(pix_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .start(start),
    .im11(im11), .im12(im12), .im13(im13), .im21(im21), .im22(im22), .im23(im23),
    .im31(im31), .im32(im32), .im33(im33), .data_occur(data_occur), .dxy(dxy),
`ifdef CANNY_THRESH_EN
    .thresh(thresh),
`endif
    .edge_valid(edge_valid), .edge_data(edge_data), .edge_x(edge_x), .edge_y(edge_y),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef logic [8:0][PW-1:0] win_t;
  typedef struct packed { logic [PW-1:0] d; logic [CW-1:0] x; logic [CW-1:0] y; } edge_t;
  typedef struct { int due; logic [PW-1:0] v; } core_t;

  win_t  win_q[$];
  edge_t edge_q[$];
  core_t core_q[$];
  int checks = 0, errors = 0;
  int lat = 3, cyc = 0, inject_req = 0, inject_done = 0;
  int starts = 0, dones = 0, in_flight = 0, win_k = 0;
  bit saw_full = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Core model: captures the window centre on start and returns it lat cycles later.
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!reset) begin
        core_q.delete();
        data_occur = 1'b0;
      end else begin
        if (start) core_q.push_back('{cyc + lat, im22});
        data_occur = 1'b0;
        if (core_q.size() > 0 && core_q[0].due == cyc) begin
          data_occur = 1'b1;
          dxy = core_q[0].v;
          void'(core_q.pop_front());
        end else if (inject_req != inject_done) begin
          data_occur = 1'b1;
          dxy = 16'd77;
          inject_done++;
        end
      end
    end
  end

  // Monitor: compares windows and edge beats against the scoreboard, watches flow control.
  initial begin
    bit acc_prev = 0, df_prev = 0;
    win_t w, ew;
    edge_t e, ee;
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_flight = 0; acc_prev = 0; df_prev = 0;
        continue;
      end
      if (start) begin
        starts++;
        in_flight++;
        w = {im33, im32, im31, im23, im22, im21, im13, im12, im11};
        if (win_q.size() == 0) chk("unexpected_start", 1'b1, 1'b0);
        else begin
          ew = win_q.pop_front();
          chk("window", w, ew);
        end
        chk("start_after_accept", acc_prev, 1'b1);
      end
      if (in_flight > OM) chk("in_flight_limit", in_flight, OM);
      if (in_flight == OM) begin
        saw_full = 1;
        chk("ready_low_when_full", pix_ready, 1'b0);
      end
      if (data_occur && in_flight > 0) in_flight--;
      if (edge_valid) begin
        e = {edge_data, edge_x, edge_y};
        if (edge_q.size() == 0) chk("unexpected_edge", e, 48'd0);
        else begin
          ee = edge_q.pop_front();
          chk("edge_beat", e, ee);
        end
      end
      if (frame_done) begin
        dones++;
        if (df_prev) chk("frame_done_width", 2, 1);
      end
      df_prev  = frame_done;
      acc_prev = pix_valid && pix_ready;
    end
  end

  // Holds pixel i until accepted; records the expected window and result for interior pixels.
  task automatic drive_pixel(input int i, input bit fs);
    bit acc = 0;
    int x = i % IW, y = i / IW;
    win_t ew;
    pix_in = PW'(i);
    pix_valid = 1'b1;
    frame_start = fs;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      acc = pix_ready;
      if (acc && x >= 2 && y >= 2) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            ew[r*3+c] = PW'((y - 2 + r) * IW + (x - 2 + c));
        win_q.push_back(ew);
        edge_q.push_back({exp_data_tbl[win_k], CW'(exp_x_tbl[win_k]), CW'(exp_y_tbl[win_k])});
        win_k++;
      end
      @(posedge clk); #1;
      frame_start = 1'b0;
      if (acc) break;
    end
    pix_valid = 1'b0;
    if (!acc) chk("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic run_frame(input bit toggle, input int fs_mid, input int stop_at);
    bit got = 0;
    starts = 0; dones = 0; win_k = 0; saw_full = 0;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int i = 0; i < IW * IH; i++) begin
      if (i == stop_at) return;
      drive_pixel(i, i == fs_mid);
      if (toggle) begin @(posedge clk); #1; end
    end
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (frame_done) begin got = 1; break; end
    end
    chk("frame_done_seen", got, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("frame_done_pulses", dones, 1);
    chk("start_count", starts, 4);
    chk("windows_drained", win_q.size(), 0);
    chk("edges_drained", edge_q.size(), 0);
    chk("idle_not_busy", busy, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix_ready", pix_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", start, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_edge_valid", edge_valid, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    lat = 3; run_frame(0, -1, -1);
    lat = 3; run_frame(1, -1, -1);
    lat = 6; run_frame(0, -1, -1);
    chk("throttle_seen", saw_full, 1'b1);
    lat = 3; run_frame(0, 6, -1);

    inject_req++;
    repeat (4) @(posedge clk);
    #1;
    chk("err_after_idle_result", err, 1'b1);
    run_frame(0, -1, -1);
    chk("err_sticky", err, 1'b1);

    run_frame(0, -1, 8);
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_pix_ready", pix_ready, 1'b0);
    chk("midrst_err", err, 1'b0);
    chk("midrst_im33", im33, 16'd0);
    chk("midrst_start", start, 1'b0);
    win_q.delete();
    edge_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_frame(0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
